sram_dp_ctrl: RTL

//  Parametrised 1RW + 1R synchronous SRAM block on a single clock: port 0 read/write, port 1 read-only.

---
 rtl/sram_dp_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sram_dp_ctrl.sv
// sram_dp_ctrl: 1RW + 1R behavioural SRAM with byte write mask, 1/2-cycle
// read latency, write-first port1 bypass and a post-reset clear sequencer.
module sram_dp_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1,
  parameter bit CLR_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_done,
  input  logic                csb0,
  input  logic                web0,
  input  logic [DATA_W/8-1:0] wmask0,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [DATA_W-1:0]   din0,
  output logic [DATA_W-1:0]   dout0,
  output logic                dout0_vld,
  input  logic                csb1,
  input  logic [ADDR_W-1:0]   addr1,
  output logic [DATA_W-1:0]   dout1,
  output logic                dout1_vld,
  output logic                collision,
  output logic                addr_err
);

  localparam int NB = DATA_W / 8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clearing;

  logic acc0;
  logic acc1;
  logic in0;
  logic in1;
  logic wr0;
  logic rd0;
  logic hit;

  logic [DATA_W-1:0] q0_raw;
  logic [DATA_W-1:0] q1_raw;
  logic [DATA_W-1:0] q1_byp;

  logic              s1_vld0;
  logic              s1_vld1;
  logic [DATA_W-1:0] s1_d0;
  logic [DATA_W-1:0] s1_d1;

  assign init_done = (state == ST_READY);
  assign clearing  = CLR_EN && (state == ST_CLEAR) && !rst;

  // Requests only count once the array is initialised; csb gates
  // every other input so unknowns on a deselected port are harmless.
  assign acc0 = init_done & ~csb0;
  assign acc1 = init_done & ~csb1;
  assign in0  = {1'b0, addr0} < DEPTH_X;
  assign in1  = {1'b0, addr1} < DEPTH_X;
  assign wr0  = acc0 & ~web0 & in0;
  assign rd0  = acc0 & web0;
  assign hit  = wr0 & acc1 & in1 & (addr0 == addr1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLR_EN ? ST_CLEAR : ST_READY;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == LAST) begin
        state <= ST_READY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clr_cnt[AW-1:0]] <= '0;
    end else if (wr0) begin
      for (int b = 0; b < NB; b++) begin
        if (wmask0[b]) begin
          mem[addr0[AW-1:0]][8*b +: 8] <= din0[8*b +: 8];
        end
      end
    end
  end

  // Port1 sees the word as it will be after this cycle's port0 write.
  always_comb begin
    q0_raw = '0;
    q1_raw = '0;
    if (in0) begin
      q0_raw = mem[addr0[AW-1:0]];
    end
    if (in1) begin
      q1_raw = mem[addr1[AW-1:0]];
    end
    q1_byp = q1_raw;
    for (int b = 0; b < NB; b++) begin
      if (hit && wmask0[b]) begin
        q1_byp[8*b +: 8] = din0[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld0   <= 1'b0;
      s1_vld1   <= 1'b0;
      s1_d0     <= '0;
      s1_d1     <= '0;
      collision <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      s1_vld0   <= rd0;
      s1_vld1   <= acc1;
      if (rd0) begin
        s1_d0 <= q0_raw;
      end
      if (acc1) begin
        s1_d1 <= q1_byp;
      end
      collision <= hit;
      addr_err  <= (acc0 & ~in0) | (acc1 & ~in1);
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              s2_vld0;
    logic              s2_vld1;
    logic [DATA_W-1:0] s2_d0;
    logic [DATA_W-1:0] s2_d1;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_vld0 <= 1'b0;
        s2_vld1 <= 1'b0;
        s2_d0   <= '0;
        s2_d1   <= '0;
      end else begin
        s2_vld0 <= s1_vld0;
        s2_vld1 <= s1_vld1;
        if (s1_vld0) begin
          s2_d0 <= s1_d0;
        end
        if (s1_vld1) begin
          s2_d1 <= s1_d1;
        end
      end
    end

    assign dout0     = s2_d0;
    assign dout0_vld = s2_vld0;
    assign dout1     = s2_d1;
    assign dout1_vld = s2_vld1;
  end else begin : g_lat1
    assign dout0     = s1_d0;
    assign dout0_vld = s1_vld0;
    assign dout1     = s1_d1;
    assign dout1_vld = s1_vld1;
  end

endmodule
